pipemem_access: RTL and testbench
=================================

Name: pipemem_access

Overview:
- Memory-stage access controller of the 5-stage pipelined CPU.
- Sits between the EX/MEM register and the MEM/WB register.
- Converts load/store requests into a req/ack data-memory bus transaction, with byte-lane alignment and load sign-extension.
- Stalls upstream stages while the bus is busy. Injects bubbles toward MEM/WB, because that register has no enable.

Parameters:
- TIMEOUT, 255: max cycles waiting for dack before abort with bus error; must be >= 1.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk, input, 1: clock, rising edge.
- clrn, input, 1: synchronous active-high reset.
- mwreg, input, 1: instruction writes the register file.
- mm2reg, input, 1: load; result comes from memory.
- mwmem, input, 1: store.
- msize, input, 2: access size; 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- msext, input, 1: sign-extend byte/half loads.
- malu, input, 32: effective address.
- mb, input, 32: store data, right-aligned.
- mmo, output, 32: formatted load data to MEM/WB.
- mwreg_o, output, 1: gated write enable to MEM/WB.
- mstall, output, 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- mexc, output, 1: one-cycle exception pulse.
- mexc_code, output, 2: 01 misaligned, 10 bus timeout.
- dreq, output, 1: bus request.
- dwe, output, 1: bus write.
- daddr, output, 32: word address; bits [1:0] forced to 0.
- dwdata, output, 32: lane-replicated store data.
- dbe, output, 4: byte enables.
- drdata, input, 32: bus read data.
- dack, input, 1: bus acknowledge.

Behaviour:
- Reset (clrn=1 at a clk edge): state IDLE, counter 0, and all registered outputs 0: dreq, dwe, daddr, dwdata, dbe, mmo, mexc, mexc_code.
- Access definition: access = mm2reg | mwmem. If both are set, the access is a load; mwmem is ignored.
- Misalignment: half access with malu[0]=1, or word access with malu[1:0]!=0.
- mstall (combinational): 1 when (state==IDLE & access & ~misaligned), or when state==REQ. 0 in DONE and ERR.
- mwreg_o (combinational): mwreg & ~mstall & ~exc_now. exc_now is the same-cycle misalign or timeout condition. A stalled or faulting instruction reaches MEM/WB as a bubble.

FSM:
- IDLE, aligned access:
  - Register daddr = {malu[31:2],2'b00} and dwe = ~mm2reg & mwmem.
  - dbe: byte 0001<<malu[1:0]; half 0011<<malu[1:0]; word 1111. Loads also drive dbe this way.
  - dwdata: byte {4{mb[7:0]}}; half {2{mb[15:0]}}; word mb.
  - Set dreq=1, counter=0, go to REQ.
- IDLE, misaligned access: no bus activity. Next cycle mexc=1, mexc_code=01. mmo unchanged. Stay in IDLE.
- IDLE, no access: outputs hold; mexc=0.
- REQ: dreq, dwe, daddr, dbe and dwdata held stable.
  - On dack=1: drop dreq; if load, capture the formatted drdata into mmo; go to DONE.
  - Else if counter==TIMEOUT-1: drop dreq, pulse mexc with code 10, go to ERR.
  - Else: counter+1.
- DONE: mstall=0 for exactly one cycle. The pipeline advances and MEM/WB captures mmo. Next state IDLE. A store leaves mmo unchanged.
- ERR: one cycle with mstall=0 and mwreg_o forced 0. Next state IDLE.
- Load formatting: lane k = malu[1:0], little-endian.
  - Byte: drdata[8k+7:8k], extended by msext (sign or zero).
  - Half: drdata[16j+15:16j] with j = malu[1], extended likewise.
  - Word: drdata as is.
- Latency: a zero-wait-state bus gives one stall cycle in IDLE, then REQ where dack arrives, then DONE. Minimum 2 stall cycles per access.
- Ignore dack in any state other than REQ.
- Reset during REQ: dreq=0 after that edge. Any dack arriving later is ignored.
- Inputs are sampled only in IDLE. Upstream holds them stable while mstall=1.
- A back-to-back access issued in IDLE immediately after DONE is legal.

Decomposition:
- Shared package pipe_pkg:
  - size encodings: SZ_BYTE, SZ_HALF, SZ_WORD
  - exception codes: EXC_MISALIGN, EXC_BUSTO
  - FSM state typedef: IDLE, REQ, DONE, ERR
- One natural sub-module, pipemem_lane: purely combinational.
  - Store lane replication and dbe generation.
  - Load extraction and extension.

Test Plan:
- Word load, malu=0x100, drdata=0xDEADBEEF, dack on first REQ cycle. Expect dreq 1 for 1 cycle, daddr=0x100, dbe=1111, mstall high 2 cycles, mmo=0xDEADBEEF in DONE, mwreg_o=1 only in DONE.
- Byte store, mb=0x000000A5, malu=0x203. Expect dwe=1, dbe=1000, dwdata=0xA5A5A5A5, daddr=0x200, mmo unchanged.
- Byte load at malu=0x2 with drdata=0x0080FF00:
  - msext=1: mmo=0xFFFFFF80.
  - msext=0: mmo=0x00000080.
  - Half load at malu=0x2, msext=1: mmo=0x00000080.
- Half load at malu=0x101. Expect no dreq, mstall=0, mwreg_o=0, mexc pulse with mexc_code=01.
- TIMEOUT=4, dack never asserted. Expect dreq high 4 cycles, then mexc with code 10, one ERR cycle with mwreg_o=0, then return to IDLE.
- clrn asserted in the 2nd REQ cycle, then dack=1. Expect dreq=0, state IDLE, mmo=0, mstall=0 after the reset edge, and the late dack ignored.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM-stage access controller: size and exception
// encodings, the controller state type, and the alignment rule.
package pipe_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_BUSTO    = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } mem_state_t;

  // The reserved size encoding behaves as a word access.
  function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/pipemem_lane.sv
// Byte-lane steering for the data bus: store replication with byte enables,
// and load-lane extraction with optional sign extension.
module pipemem_lane
  import pipe_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] mb,
  input  logic [1:0]  ld_size,
  input  logic        ld_sext,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] drdata,
  output logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = drdata[{ld_lane, 3'b000} +: 8];
  assign ld_half = drdata[{ld_lane[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    st_data = mb;
    st_be   = 4'b1111;
    case (st_size)
      SZ_BYTE: begin
        st_data = {4{mb[7:0]}};
        st_be   = 4'b0001 << st_lane;
      end
      SZ_HALF: begin
        st_data = {2{mb[15:0]}};
        st_be   = 4'b0011 << st_lane;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = drdata;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_sext & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_sext & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/pipemem_access.sv
// MEM-stage access controller: turns load/store requests into req/ack bus
// transactions, stalls upstream while busy and feeds bubbles to MEM/WB.
module pipemem_access
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [1:0]  msize,
  input  logic        msext,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  output logic [31:0] mmo,
  output logic        mwreg_o,
  output logic        mstall,
  output logic        mexc,
  output logic [1:0]  mexc_code,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dbe,
  input  logic [31:0] drdata,
  input  logic        dack
);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       r_size;
  logic [1:0]       r_lane;
  logic             r_sext;
  logic             r_load;

  logic        access;
  logic        misaligned;
  logic        timeout_now;
  logic        exc_now;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [31:0] ld_data;

  assign access      = mm2reg | mwmem;
  assign misaligned  = addr_misaligned(msize, malu[1:0]);
  assign timeout_now = (state == REQ) & ~dack & (cnt == CNT_W'(TIMEOUT - 1));
  // ERR is the cycle the faulting instruction leaves; it must arrive as a bubble.
  assign exc_now     = ((state == IDLE) & access & misaligned) | timeout_now | (state == ERR);
  assign mstall      = ((state == IDLE) & access & ~misaligned) | (state == REQ);
  assign mwreg_o     = mwreg & ~mstall & ~exc_now;

  // Store formatting uses the live request; load formatting uses the
  // attributes latched at issue, since inputs are only trusted in IDLE.
  pipemem_lane u_lane (
    .st_size (msize),
    .st_lane (malu[1:0]),
    .mb      (mb),
    .ld_size (r_size),
    .ld_sext (r_sext),
    .ld_lane (r_lane),
    .drdata  (drdata),
    .st_data (st_data),
    .st_be   (st_be),
    .ld_data (ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every read in this block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (clrn) begin
      state     <= IDLE;
      cnt       <= '0;
      r_size    <= SZ_BYTE;
      r_lane    <= 2'b00;
      r_sext    <= 1'b0;
      r_load    <= 1'b0;
      dreq      <= 1'b0;
      dwe       <= 1'b0;
      daddr     <= '0;
      dwdata    <= '0;
      dbe       <= '0;
      mmo       <= '0;
      mexc      <= 1'b0;
      mexc_code <= EXC_NONE;
    end else begin
      mexc <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (misaligned) begin
              mexc      <= 1'b1;
              mexc_code <= EXC_MISALIGN;
            end else begin
              daddr  <= {malu[31:2], 2'b00};
              dwe    <= ~mm2reg & mwmem;
              dbe    <= st_be;
              dwdata <= st_data;
              dreq   <= 1'b1;
              cnt    <= '0;
              r_size <= msize;
              r_lane <= malu[1:0];
              r_sext <= msext;
              r_load <= mm2reg;
              state  <= REQ;
            end
          end
        end
        REQ: begin
          if (dack) begin
            dreq <= 1'b0;
            if (r_load) mmo <= ld_data;
            state <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            dreq      <= 1'b0;
            mexc      <= 1'b1;
            mexc_code <= EXC_BUSTO;
            state     <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipemem_access.sv
// Self-checking bench for pipemem_access: directed cases plus randomized
// accesses against a transaction-level reference model.
module tb_pipemem_access;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  logic        clk = 1'b0;
  logic        clrn;
  logic        mwreg, mm2reg, mwmem, msext, dack;
  logic [1:0]  msize;
  logic [31:0] malu, mb, drdata;
  logic [31:0] mmo, daddr, dwdata;
  logic        mwreg_o, mstall, mexc, dreq, dwe;
  logic [1:0]  mexc_code;
  logic [3:0]  dbe;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_mmo = 32'h0;

  always #5 clk = ~clk;

  pipemem_access #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .msize(msize), .msext(msext), .malu(malu), .mb(mb), .mmo(mmo),
    .mwreg_o(mwreg_o), .mstall(mstall), .mexc(mexc), .mexc_code(mexc_code),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dbe(dbe),
    .drdata(drdata), .dack(dack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sx,
                                         input logic [31:0] a, input logic [31:0] rd);
    int unsigned k = a % 4;
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * k)) & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * (k / 2))) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int unsigned k = a % 4;
    if (sz == 2'd0) return 32'(1 << k);
    if (sz == 2'd1) return 32'(3 << k);
    return 32'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  task automatic set_idle;
    mm2reg = 1'b0;
    mwmem  = 1'b0;
    mwreg  = 1'b0;
  endtask

  // wait_cyc: REQ cycle (0-based) in which dack is raised; negative means never.
  task automatic run_access(input logic ld, input logic st, input logic wr,
                            input logic [1:0] sz, input logic sx,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] rd, input int wait_cyc);
    bit acked = 0;
    mm2reg = ld; mwmem = st; mwreg = wr; msize = sz; msext = sx;
    malu = addr; mb = data; drdata = rd;
    dack = 1'($urandom_range(0, 1));
    #1;
    if (!(ld || st)) begin
      check("noacc_stall", mstall, 0);
      check("noacc_wreg", mwreg_o, wr);
      tick;
      check("noacc_dreq", dreq, 0);
      check("noacc_exc", mexc, 0);
      return;
    end
    if (m_misaligned(sz, addr)) begin
      check("mis_stall", mstall, 0);
      check("mis_wreg", mwreg_o, 0);
      tick;
      check("mis_dreq", dreq, 0);
      check("mis_exc", mexc, 1);
      check("mis_code", mexc_code, 2'b01);
      check("mis_mmo", mmo, model_mmo);
      return;
    end
    check("iss_stall", mstall, 1);
    check("iss_wreg", mwreg_o, 0);
    tick;
    dack = 1'b0;
    check("req_daddr", daddr, addr & 32'hFFFFFFFC);
    check("req_dbe", dbe, m_be(sz, addr));
    check("req_dwe", dwe, st && !ld);
    check("req_dwdata", dwdata, m_wdata(sz, data));
    for (int n = 0; n < TIMEOUT; n++) begin
      check("req_dreq", dreq, 1);
      check("req_stall", mstall, 1);
      check("req_wreg", mwreg_o, 0);
      if (n == wait_cyc) dack = 1'b1;
      tick;
      if (dack) begin
        acked = 1;
        break;
      end
    end
    dack = 1'($urandom_range(0, 1));
    #1;
    if (acked) begin
      if (ld) model_mmo = m_load(sz, sx, addr, rd);
      check("done_dreq", dreq, 0);
      check("done_stall", mstall, 0);
      check("done_wreg", mwreg_o, wr);
      check("done_exc", mexc, 0);
      check("done_mmo", mmo, model_mmo);
    end else begin
      check("err_dreq", dreq, 0);
      check("err_stall", mstall, 0);
      check("err_wreg", mwreg_o, 0);
      check("err_exc", mexc, 1);
      check("err_code", mexc_code, 2'b10);
      check("err_mmo", mmo, model_mmo);
    end
    tick;
    dack = 1'b0;
  endtask

  initial begin
    clrn = 1'b1; dack = 1'b0; msize = 2'b00; msext = 1'b0;
    malu = '0; mb = '0; drdata = '0;
    set_idle;
    tick;
    tick;
    clrn = 1'b0;
    #1;
    check("rst_dreq", dreq, 0);
    check("rst_dwe", dwe, 0);
    check("rst_daddr", daddr, 0);
    check("rst_dwdata", dwdata, 0);
    check("rst_dbe", dbe, 0);
    check("rst_mmo", mmo, 0);
    check("rst_mexc", mexc, 0);
    check("rst_code", mexc_code, 0);
    check("rst_stall", mstall, 0);

    // Directed cases
    run_access(1, 0, 1, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    run_access(0, 1, 0, 2'b00, 0, 32'h203, 32'h000000A5, 32'h0, 1);
    run_access(1, 0, 1, 2'b00, 1, 32'h2, 32'h0, 32'h0080FF00, 0);
    run_access(1, 0, 1, 2'b00, 0, 32'h2, 32'h0, 32'h0080FF00, 2);
    run_access(1, 0, 1, 2'b01, 1, 32'h2, 32'h0, 32'h0080FF00, 3);
    run_access(1, 0, 1, 2'b01, 0, 32'h101, 32'h0, 32'h12345678, 0);
    run_access(1, 0, 1, 2'b10, 0, 32'h40, 32'h0, 32'h0, -1);
    run_access(1, 1, 1, 2'b11, 0, 32'h80, 32'h55AA55AA, 32'h89ABCDEF, 0);

    // Reset in the second REQ cycle, then a late dack
    mm2reg = 1'b1; mwmem = 1'b0; mwreg = 1'b1; msize = 2'b10; msext = 1'b0;
    malu = 32'h44; drdata = 32'hCAFEF00D; dack = 1'b0;
    tick;
    tick;
    clrn = 1'b1;
    tick;
    clrn = 1'b0;
    set_idle;
    dack = 1'b1;
    #1;
    model_mmo = 32'h0;
    check("rstreq_dreq", dreq, 0);
    check("rstreq_stall", mstall, 0);
    check("rstreq_mmo", mmo, 0);
    tick;
    check("late_dack_dreq", dreq, 0);
    check("late_dack_stall", mstall, 0);
    check("late_dack_mmo", mmo, 0);
    dack = 1'b0;

    // Randomized accesses, biased towards aligned addresses
    for (int i = 0; i < 120; i++) begin
      int unsigned kind = $urandom_range(0, 3);
      int unsigned w    = $urandom_range(0, 7);
      logic [1:0]  sz   = 2'($urandom_range(0, 3));
      logic [31:0] a    = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & 32'hFFFFFFFE;
        else if (sz != 2'd0) a = a & 32'hFFFFFFFC;
      end
      run_access(kind == 1 || kind == 3, kind >= 2, 1'($urandom_range(0, 1)), sz,
                 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                 (w >= 6) ? -1 : int'(w % 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
